// File: rtl/dbiu_mem_responder.sv
// Data-bus responder: services a single CPU data-bus port from a local word memory.
// Each request is acknowledged a fixed, programmable number of cycles after it is captured.
// Optional feature macro: DBIU_RESP_PERF_CNT_EN adds read/write completion counters.
`timescale 1ns/1ps

module dbiu_mem_responder #(
    parameter int unsigned DBUS_AW     = 32,
    parameter int unsigned DBUS_DW     = 32,
    parameter int unsigned DBUS_ISEL   = DBUS_DW / 8,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_m2dbiu,
    input  logic [DBUS_AW-1:0]   adr_m2dbiu,
    input  logic [DBUS_DW-1:0]   dat_m2dbiu,
    input  logic                 we_m2dbiu,
    input  logic [DBUS_ISEL-1:0] sel_m2dbiu,
`ifdef DBIU_RESP_PERF_CNT_EN
    output logic [31:0]          rd_cnt_o,
    output logic [31:0]          wr_cnt_o,
`endif
    output logic [DBUS_DW-1:0]   dat_dbiu2m,
    output logic                 ack_dbiu2m
);

    localparam int unsigned OffW = $clog2(DBUS_ISEL);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DBUS_DW-1:0]     wdat_q, wdat_d;
    logic                   we_q, we_d;
    logic [DBUS_ISEL-1:0]   sel_q, sel_d;
    logic [DBUS_DW-1:0]     rdat_q, rdat_d;
    logic                   ack_q, ack_d;

    logic [DBUS_DW-1:0]     mem [DEPTH_WORDS];
    logic [DBUS_DW-1:0]     merged_word;
    logic                   finish;

    // Only the word-index bits matter; offset bits and upper bits alias.
    logic unused_adr;
    assign unused_adr = ^adr_m2dbiu;

    // The transaction completes on the edge that takes WAIT into ACK.
    assign finish = (state_q == StWait) && (cnt_q == 4'd1);

    // Byte-merge captured write data over the currently stored word.
    always_comb begin
        merged_word = mem[idx_q];
        for (int b = 0; b < int'(DBUS_ISEL); b++) begin
            if (sel_q[b]) merged_word[8*b +: 8] = wdat_q[8*b +: 8];
        end
    end

    // Next-state logic: capture, count down, pulse ack, wait for req release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_m2dbiu) begin
                    idx_d   = adr_m2dbiu[OffW +: IdxW];
                    wdat_d  = dat_m2dbiu;
                    we_d    = we_m2dbiu;
                    sel_d   = sel_m2dbiu;
                    // Counter starts at LATENCY so the ack edge lands LATENCY edges after capture.
                    cnt_d   = 4'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (finish) begin
                    state_d = StAck;
                    ack_d   = 1'b1;
                    if (!we_q) rdat_d = mem[idx_q];
                end
            end
            StAck: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!req_m2dbiu) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and holding registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
        end
    end

    // Memory array is not reset; a write commits only on completion.
    always_ff @(posedge clk) begin
        if (finish && we_q) mem[idx_q] <= merged_word;
    end

    assign dat_dbiu2m = rdat_q;
    assign ack_dbiu2m = ack_q;

`ifdef DBIU_RESP_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    // Count completions during the ack cycle; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (state_q == StAck) begin
            if (we_q) wr_cnt_q <= wr_cnt_q + 32'd1;
            else      rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dbiu_mem_responder.sv
// Directed bench for dbiu_mem_responder with LATENCY=2, DEPTH_WORDS=256.
`timescale 1ns/1ps

module tb_dbiu_mem_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] rdat;
    logic        ack;
`ifdef DBIU_RESP_PERF_CNT_EN
    logic [31:0] rd_cnt, wr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbiu_mem_responder #(
        .DBUS_AW    (32),
        .DBUS_DW    (32),
        .DBUS_ISEL  (4),
        .DEPTH_WORDS(256),
        .LATENCY    (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_m2dbiu(req),
        .adr_m2dbiu(adr),
        .dat_m2dbiu(wdat),
        .we_m2dbiu (we),
        .sel_m2dbiu(sel),
`ifdef DBIU_RESP_PERF_CNT_EN
        .rd_cnt_o  (rd_cnt),
        .wr_cnt_o  (wr_cnt),
`endif
        .dat_dbiu2m(rdat),
        .ack_dbiu2m(ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Wait for ack after req was raised; returns edges from capture edge to ack edge.
    task automatic wait_ack(output int lat);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 20);
        lat = ack ? n - 1 : -1;
    endtask

    // Full transaction: raise req, wait for ack, hold req 'hold' cycles, drop it.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int hold,
                        input logic [31:0] exp_rd, input logic chk_rd);
        int lat;
        req = 1'b1; we = w; adr = a; wdat = d; sel = s;
        wait_ack(lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        if (chk_rd) check({tag, "_rdat"}, rdat, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_noack_hold"}, {31'd0, ack}, 32'd0);
        end
        if (hold == 0) begin
            @(posedge clk); #1;
            check({tag, "_pulse"}, {31'd0, ack}, 32'd0);
        end
        req = 1'b0; we = 1'b0; wdat = '0; sel = '0;
        @(posedge clk); #1;
        if (hold == 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read back
        xfer("wr_full", 1'b1, 32'h000, 32'hDEADBEEF, 4'b1111, 0, '0, 1'b0);
        xfer("rd_full", 1'b0, 32'h000, 32'h0, 4'b0000, 0, 32'hDEADBEEF, 1'b1);
        check("dat_hold", rdat, 32'hDEADBEEF);

        // Partial byte write merges over stored word; write leaves read data alone
        xfer("wr_byte1", 1'b1, 32'h000, 32'h0000AA00, 4'b0010, 0, '0, 1'b0);
        check("dat_after_wr", rdat, 32'hDEADBEEF);
        xfer("rd_merge", 1'b0, 32'h000, 32'h0, 4'b0000, 0, 32'hDEADAAEF, 1'b1);

        // Req held after ack: no second ack; one low cycle then a new request
        xfer("rd_hold", 1'b0, 32'h000, 32'h0, 4'b0000, 3, 32'hDEADAAEF, 1'b1);
        xfer("rd_again", 1'b0, 32'h000, 32'h0, 4'b0000, 0, 32'hDEADAAEF, 1'b1);

        // Address wrap: 0x400 aliases word 0; low offset bits ignored
        xfer("wr_wrap", 1'b1, 32'h400, 32'h00000011, 4'b1111, 0, '0, 1'b0);
        xfer("rd_wrap", 1'b0, 32'h003, 32'h0, 4'b0000, 0, 32'h00000011, 1'b1);

        // Reset in WAIT discards the write
        xfer("wr_pre", 1'b1, 32'h004, 32'h00000000, 4'b1111, 0, '0, 1'b0);
        req = 1'b1; we = 1'b1; adr = 32'h004; wdat = 32'hFFFFFFFF; sel = 4'b1111;
        @(posedge clk); #1;
        resetn = 1'b0;
        #2;
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_dat", rdat, 32'h0);
`ifdef DBIU_RESP_PERF_CNT_EN
        check("rst_rd_cnt", rd_cnt, 32'd0);
        check("rst_wr_cnt", wr_cnt, 32'd0);
`endif
        req = 1'b0; we = 1'b0; wdat = '0; sel = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_mid_noack", {31'd0, ack}, 32'd0);
        end
        xfer("rd_discard", 1'b0, 32'h004, 32'h0, 4'b0000, 0, 32'h00000000, 1'b1);
        xfer("rd_keep", 1'b0, 32'h000, 32'h0, 4'b0000, 0, 32'h00000011, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
